// File: rtl/player_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : player_cmd_arbiter_if
//  Description : Bundles the requester handshake bus and the Player-side
//                outputs of player_cmd_arbiter.
//                  req_valid   [N_REQ]    request pending per requester
//                  req_instr   [16*N_REQ] instruction per requester (slot i)
//                  req_ready   [N_REQ]    one-cycle accept pulse
//                  tick_10hz              10 Hz strobe in the clk domain
//                  is_death               Player death flag
//                  instruction [16]       instruction to Player (0 = NOP)
//                  busy                   arbiter not idle
//                  drop_count  [8]        saturating dropped-command count
//                master: requesters / game side, slave: the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface player_cmd_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_instr;
    logic [N_REQ-1:0]    req_ready;
    logic                tick_10hz;
    logic                is_death;
    logic [15:0]         instruction;
    logic                busy;
    logic [7:0]          drop_count;

    modport master (
        output req_valid, req_instr, tick_10hz, is_death,
        input  req_ready, instruction, busy, drop_count
    );

    modport slave (
        input  req_valid, req_instr, tick_10hz, is_death,
        output req_ready, instruction, busy, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/player_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : player_cmd_arbiter
//  Description : Round-robin arbiter sharing the Player 16-bit instruction
//                bus between N_REQ requesters. Stat ops are issued for one
//                clk, move ops (opcode 5) are held until a tick_10hz strobe
//                (or dropped after MOVE_TIMEOUT clks), and every issue is
//                followed by one NOP gap cycle.
//  Ports       : clk    system clock
//                reset  asynchronous active-high reset
//                bus    player_cmd_arbiter_if.slave (handshake + outputs)
//  Parameters  : N_REQ (2..8), MOVE_TIMEOUT (clks a move waits for a tick)
//  Macro       : DEATH_GATE_EN - when defined, only opcodes 4 and 6 are
//                issued while is_death is high at grant; the rest are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module player_cmd_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MOVE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    player_cmd_arbiter_if.slave  bus
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW   = $clog2(MOVE_TIMEOUT + 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ISSUE     = 3'd1;
    localparam logic [2:0] c_ST_MOVE_WAIT = 3'd2;
    localparam logic [2:0] c_ST_HOLD      = 3'd3;
    localparam logic [2:0] c_ST_GAP       = 3'd4;

    localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [IDXW-1:0]  r_rr_ptr;
    logic [15:0]      r_instruction;
    logic [N_REQ-1:0] r_req_ready;
    logic [7:0]       r_drop_count;
    logic [CW-1:0]    r_wait_cnt;

    logic [15:0]      w_slot [N_REQ];
    logic [N_REQ-1:0] w_valid;
    logic             w_found;
    logic [IDXW-1:0]  w_idx;
    logic [IDXW-1:0]  w_rr_next;
    logic [15:0]      w_sel_instr;
    logic [3:0]       w_op;
    logic             w_is_stat;
    logic             w_is_move;
    logic             w_is_nop;
    logic             w_gated;
    logic [CW-1:0]    w_cnt_next;
    logic             w_timeout;
    logic             w_drop_evt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign w_slot[g] = bus.req_instr[16*g +: 16];
    end

    // A requester sees its ready pulse during the cycle after the grant and
    // is still holding valid then; masking it prevents a second grant of the
    // same transfer when the arbiter stays in IDLE (NOP / dropped ops).
    assign w_valid = bus.req_valid & ~r_req_ready;

    always_comb begin
        logic [IDXW:0] v_sum;
        w_found = 1'b0;
        w_idx   = '0;
        v_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (IDXW+1)'(k);
            if (v_sum >= (IDXW+1)'(N_REQ)) begin
                v_sum = v_sum - (IDXW+1)'(N_REQ);
            end
            if (!w_found && w_valid[v_sum[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_sum[IDXW-1:0];
            end
        end
    end

    assign w_rr_next   = (w_idx == IDXW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_sel_instr = w_slot[w_idx];
    assign w_op        = w_sel_instr[15:12];
    assign w_is_nop    = (w_op == 4'h0);
    assign w_is_move   = (w_op == 4'h5);
    assign w_is_stat   = (w_op == 4'h1) || (w_op == 4'h2) || (w_op == 4'h3) ||
                         (w_op == 4'h4) || (w_op == 4'h6);

`ifdef DEATH_GATE_EN
    // Only set-ATK / set-HP may reach a dead Player.
    assign w_gated = bus.is_death && !((w_op == 4'h4) || (w_op == 4'h6));
`else
    logic w_unused_death;
    assign w_unused_death = bus.is_death;
    assign w_gated        = 1'b0;
`endif

    assign w_cnt_next = r_wait_cnt + 1'b1;
    assign w_timeout  = (w_cnt_next == CW'(MOVE_TIMEOUT));

    // Drops: an illegal or gated opcode granted in IDLE, or a move whose wait
    // expires without a tick (a tick on the timeout cycle wins).
    assign w_drop_evt =
        ((r_state == c_ST_IDLE) && w_found && !w_is_nop &&
         (w_gated || !(w_is_stat || w_is_move))) ||
        ((r_state == c_ST_MOVE_WAIT) && !bus.tick_10hz && w_timeout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_rr_ptr      <= '0;
            r_instruction <= '0;
            r_req_ready   <= '0;
            r_drop_count  <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    r_instruction <= '0;
                    if (w_found) begin
                        r_req_ready <= c_ONE << w_idx;
                        r_rr_ptr    <= w_rr_next;
                        if (!w_gated && w_is_stat) begin
                            r_instruction <= w_sel_instr;
                            r_state       <= c_ST_ISSUE;
                        end else if (!w_gated && w_is_move) begin
                            r_instruction <= w_sel_instr;
                            r_wait_cnt    <= '0;
                            r_state       <= c_ST_MOVE_WAIT;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_instruction <= '0;
                    r_state       <= c_ST_GAP;
                end
                c_ST_MOVE_WAIT: begin
                    if (bus.tick_10hz) begin
                        r_state <= c_ST_HOLD;
                    end else if (w_timeout) begin
                        r_instruction <= '0;
                        r_state       <= c_ST_GAP;
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                    end
                end
                c_ST_HOLD: begin
                    r_instruction <= '0;
                    r_state       <= c_ST_GAP;
                end
                c_ST_GAP: begin
                    r_instruction <= '0;
                    r_state       <= c_ST_IDLE;
                end
                default: begin
                    r_instruction <= '0;
                    r_state       <= c_ST_IDLE;
                end
            endcase
            if (w_drop_evt && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.instruction = r_instruction;
    assign bus.req_ready   = r_req_ready;
    assign bus.drop_count  = r_drop_count;
    assign bus.busy        = (r_state != c_ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_player_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_cmd_arbiter
//  Description : Directed self-checking bench for player_cmd_arbiter
//                (N_REQ=4, MOVE_TIMEOUT=8). Inputs change and outputs are
//                checked on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_player_cmd_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    player_cmd_arbiter_if #(.N_REQ(4)) bus ();

    player_cmd_arbiter #(
        .N_REQ        (4),
        .MOVE_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] v);
        bus.req_instr[16*i +: 16] = v;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_2010;
        logic [15:0] exp_busy;
        logic [15:0] exp_drop;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_instr = '0;
        bus.tick_10hz = 1'b0;
        bus.is_death  = 1'b0;
        step(); step();

        // Reset state
        chk("rst_instr", bus.instruction, 16'h0000);
        chk("rst_ready", {12'h0, bus.req_ready}, 16'h0000);
        chk("rst_busy",  {15'h0, bus.busy}, 16'h0000);
        chk("rst_drop",  {8'h0, bus.drop_count}, 16'h0000);
        reset = 1'b0;

        // T1: single stat op from requester 1
        set_slot(1, 16'h1050); bus.req_valid = 4'b0010; step();
        chk("t1_ready", {12'h0, bus.req_ready}, 16'h0002);
        chk("t1_instr", bus.instruction, 16'h1050);
        chk("t1_busy",  {15'h0, bus.busy}, 16'h0001);
        bus.req_valid = '0; step();
        chk("t1_gap_instr", bus.instruction, 16'h0000);
        chk("t1_gap_ready", {12'h0, bus.req_ready}, 16'h0000);
        step();
        chk("t1_idle_busy", {15'h0, bus.busy}, 16'h0000);

        // T2: rr from 0 with requesters 0 and 2 both pending
        reset = 1'b1; step(); reset = 1'b0;
        set_slot(0, 16'h1111); set_slot(2, 16'h2222); bus.req_valid = 4'b0101; step();
        chk("t2_g0_ready", {12'h0, bus.req_ready}, 16'h0001);
        chk("t2_g0_instr", bus.instruction, 16'h1111);
        bus.req_valid = 4'b0100; step();
        chk("t2_gap_instr", bus.instruction, 16'h0000);
        step();
        chk("t2_idle_ready", {12'h0, bus.req_ready}, 16'h0000);
        step();
        chk("t2_g2_ready", {12'h0, bus.req_ready}, 16'h0004);
        chk("t2_g2_instr", bus.instruction, 16'h2222);
        bus.req_valid = '0; step(); step();
        // rr_ptr is now 3: requester 3 beats requester 0
        set_slot(3, 16'h3333); bus.req_valid = 4'b1001; step();
        chk("t2_g3_ready", {12'h0, bus.req_ready}, 16'h0008);
        chk("t2_g3_instr", bus.instruction, 16'h3333);
        bus.req_valid = 4'b0001; step(); step(); step();
        chk("t2_wrap_ready", {12'h0, bus.req_ready}, 16'h0001);
        chk("t2_wrap_instr", bus.instruction, 16'h1111);
        bus.req_valid = '0; step(); step();

        // T3: move op from requester 1, tick on 5th wait cycle
        set_slot(1, 16'h5020); bus.req_valid = 4'b0010; step();
        chk("t3_mw1_ready", {12'h0, bus.req_ready}, 16'h0002);
        chk("t3_mw1_instr", bus.instruction, 16'h5020);
        bus.req_valid = '0; step();
        chk("t3_mw2_ready", {12'h0, bus.req_ready}, 16'h0000);
        step(); step(); step();
        bus.tick_10hz = 1'b1;
        chk("t3_mw5_instr", bus.instruction, 16'h5020);
        step();
        bus.tick_10hz = 1'b0;
        chk("t3_hold_instr", bus.instruction, 16'h5020);
        step();
        chk("t3_gap_instr", bus.instruction, 16'h0000);
        chk("t3_gap_busy",  {15'h0, bus.busy}, 16'h0001);
        step();
        chk("t3_idle_busy", {15'h0, bus.busy}, 16'h0000);
        chk("t3_drop",      {8'h0, bus.drop_count}, 16'h0000);

        // T4: move op from requester 2, no tick -> timeout after 8 cycles
        set_slot(2, 16'h5000); bus.req_valid = 4'b0100; step();
        chk("t4_mw1_ready", {12'h0, bus.req_ready}, 16'h0004);
        chk("t4_mw1_instr", bus.instruction, 16'h5000);
        bus.req_valid = '0;
        for (int c = 2; c <= 8; c++) begin
            step();
            chk($sformatf("t4_mw%0d_instr", c), bus.instruction, 16'h5000);
        end
        step();
        chk("t4_to_instr", bus.instruction, 16'h0000);
        chk("t4_to_drop",  {8'h0, bus.drop_count}, 16'h0001);
        chk("t4_to_busy",  {15'h0, bus.busy}, 16'h0001);
        step();
        chk("t4_idle_busy", {15'h0, bus.busy}, 16'h0000);

        // T5: async reset in the middle of MOVE_WAIT (rr_ptr 3 -> grants 1)
        set_slot(1, 16'h5111); bus.req_valid = 4'b0010; step();
        chk("t5_mw1_ready", {12'h0, bus.req_ready}, 16'h0002);
        bus.req_valid = '0;
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_instr", bus.instruction, 16'h0000);
        chk("t5_rst_ready", {12'h0, bus.req_ready}, 16'h0000);
        chk("t5_rst_busy",  {15'h0, bus.busy}, 16'h0000);
        chk("t5_rst_drop",  {8'h0, bus.drop_count}, 16'h0000);
        step();
        reset = 1'b0;
        set_slot(0, 16'h1AAA); set_slot(2, 16'h2BBB); bus.req_valid = 4'b0101; step();
        chk("t5_post_ready", {12'h0, bus.req_ready}, 16'h0001);
        chk("t5_post_instr", bus.instruction, 16'h1AAA);
        bus.req_valid = '0; step(); step();

        // NOP opcode: accepted, nothing issued, not a drop (rr_ptr=1)
        set_slot(1, 16'h0123); bus.req_valid = 4'b0010; step();
        chk("nop_ready", {12'h0, bus.req_ready}, 16'h0002);
        chk("nop_instr", bus.instruction, 16'h0000);
        chk("nop_busy",  {15'h0, bus.busy}, 16'h0000);
        chk("nop_drop",  {8'h0, bus.drop_count}, 16'h0000);
        bus.req_valid = '0; step();

        // Illegal opcode: accepted and dropped (rr_ptr=2)
        set_slot(2, 16'hA000); bus.req_valid = 4'b0100; step();
        chk("ill_ready", {12'h0, bus.req_ready}, 16'h0004);
        chk("ill_instr", bus.instruction, 16'h0000);
        chk("ill_busy",  {15'h0, bus.busy}, 16'h0000);
        chk("ill_drop",  {8'h0, bus.drop_count}, 16'h0001);
        bus.req_valid = '0; step();

        // T6: death gate (rr_ptr=3)
`ifdef DEATH_GATE_EN
        exp_2010 = 16'h0000; exp_busy = 16'h0000; exp_drop = 16'h0002;
`else
        exp_2010 = 16'h2010; exp_busy = 16'h0001; exp_drop = 16'h0001;
`endif
        bus.is_death = 1'b1;
        set_slot(3, 16'h2010); bus.req_valid = 4'b1000; step();
        chk("t6_a_ready", {12'h0, bus.req_ready}, 16'h0008);
        chk("t6_a_instr", bus.instruction, exp_2010);
        chk("t6_a_busy",  {15'h0, bus.busy}, exp_busy);
        bus.req_valid = '0; step(); step();
        chk("t6_a_drop",  {8'h0, bus.drop_count}, exp_drop);
        set_slot(0, 16'h6640); bus.req_valid = 4'b0001; step();
        chk("t6_b_ready", {12'h0, bus.req_ready}, 16'h0001);
        chk("t6_b_instr", bus.instruction, 16'h6640);
        bus.req_valid = '0; step();
        chk("t6_b_gap",   bus.instruction, 16'h0000);
        step();
        chk("t6_b_drop",  {8'h0, bus.drop_count}, exp_drop);
        bus.is_death = 1'b0;

        // drop_count saturation
        set_slot(0, 16'hF000);
        for (int n = 0; n < 260; n++) begin
            bus.req_valid = 4'b0001; step();
            bus.req_valid = '0; step();
        end
        chk("sat_drop", {8'h0, bus.drop_count}, 16'h00FF);
        chk("sat_busy", {15'h0, bus.busy}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
